// File: rtl/fp_align_add.sv
// rtl/fp_align_add.sv - IEEE-754 single add/sub front end: unpack, order, align and add mantissas.
// Alignment is sequential (one bit per cycle, capped at MAX_SHIFT) and the result waits for a normalize stage.
module fp_align_add #(
   parameter int MAX_SHIFT = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   input  logic        operator_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        sign_out,
   output logic [7:0]  exp_out,
   output logic [25:0] mantis_out,
   output logic        operator_out,
   output logic        loss
);

   localparam int CW = $clog2(MAX_SHIFT + 1);
   localparam logic [7:0] MAX8 = 8'(MAX_SHIFT);

   typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;

   state_t        state_q, state_d;
   logic          l_sign_q, l_sign_d;
   logic [7:0]    l_exp_q, l_exp_d;
   logic [25:0]   l_mant_q, l_mant_d;
   logic [25:0]   s_mant_q, s_mant_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sticky_q, sticky_d;
   logic          eop_q, eop_d;
   logic          sign_q, sign_d;
   logic [7:0]    exp_q, exp_d;
   logic [25:0]   mant_q, mant_d;
   logic          loss_q, loss_d;

   logic [7:0]  a_exp, b_exp, l_exp_in, s_exp_in, d_in, shift_in;
   logic [25:0] a_mant, b_mant, l_mant_in, s_mant_in, sum, diff, res;
   logic [30:0] a_key, b_key;
   logic        a_is_l, b_sign_eff, accept;

   // Zero-exponent operands collapse to true zero for both mantissa and magnitude ordering.
   always_comb begin
      a_exp      = a_in[30:23];
      b_exp      = b_in[30:23];
      a_mant     = (a_exp == 8'd0) ? 26'd0 : {1'b0, 1'b1, a_in[22:0], 1'b0};
      b_mant     = (b_exp == 8'd0) ? 26'd0 : {1'b0, 1'b1, b_in[22:0], 1'b0};
      a_key      = (a_exp == 8'd0) ? 31'd0 : a_in[30:0];
      b_key      = (b_exp == 8'd0) ? 31'd0 : b_in[30:0];
      a_is_l     = (a_key >= b_key);
      b_sign_eff = b_in[31] ^ operator_in;
      l_exp_in   = a_is_l ? a_exp : b_exp;
      s_exp_in   = a_is_l ? b_exp : a_exp;
      l_mant_in  = a_is_l ? a_mant : b_mant;
      s_mant_in  = a_is_l ? b_mant : a_mant;
      d_in       = l_exp_in - s_exp_in;
      shift_in   = (d_in > MAX8) ? MAX8 : d_in;
      accept     = in_valid && (state_q == IDLE);
      sum        = l_mant_q + s_mant_q;
      diff       = l_mant_q - s_mant_q;
      res        = eop_q ? diff : sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (d_in != 8'd0) ? ALIGN : ADD;
         ALIGN:   if (cnt_q == CW'(1)) state_d = ADD;
         ADD:     state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   always_comb begin
      l_sign_d = l_sign_q;
      l_exp_d  = l_exp_q;
      l_mant_d = l_mant_q;
      s_mant_d = s_mant_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      eop_d    = eop_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      mant_d   = mant_q;
      loss_d   = loss_q;
      if (accept) begin
         l_sign_d = a_is_l ? a_in[31] : b_sign_eff;
         l_exp_d  = l_exp_in;
         l_mant_d = l_mant_in;
         s_mant_d = s_mant_in;
         cnt_d    = CW'(shift_in);
         sticky_d = 1'b0;
         eop_d    = a_in[31] ^ b_in[31] ^ operator_in;
      end else if (state_q == ALIGN) begin
         s_mant_d = s_mant_q >> 1;
         sticky_d = sticky_q | s_mant_q[0];
         cnt_d    = cnt_q - CW'(1);
      end else if (state_q == ADD) begin
         // L >= S and L carries the hidden bit, so a zero difference is always exact.
         if (eop_q && (diff == 26'd0)) begin
            sign_d = 1'b0;
            exp_d  = 8'd0;
            mant_d = 26'd0;
            loss_d = 1'b0;
         end else begin
            sign_d = l_sign_q;
            exp_d  = l_exp_q;
            mant_d = res;
            loss_d = sticky_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_sign_q <= 1'b0;
         l_exp_q  <= 8'd0;
         l_mant_q <= 26'd0;
         s_mant_q <= 26'd0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         eop_q    <= 1'b0;
         sign_q   <= 1'b0;
         exp_q    <= 8'd0;
         mant_q   <= 26'd0;
         loss_q   <= 1'b0;
      end else begin
         l_sign_q <= l_sign_d;
         l_exp_q  <= l_exp_d;
         l_mant_q <= l_mant_d;
         s_mant_q <= s_mant_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         eop_q    <= eop_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         mant_q   <= mant_d;
         loss_q   <= loss_d;
      end
   end

   assign sign_out     = sign_q;
   assign exp_out      = exp_q;
   assign mantis_out   = mant_q;
   assign operator_out = eop_q;
   assign loss         = loss_q;

endmodule

// File: tb/tb_fp_align_add.sv
// tb/tb_fp_align_add.sv - directed and randomized checks of fp_align_add against an arithmetic model.
module tb_fp_align_add;

   localparam int MAX = 26;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a_in = 32'd0;
   logic [31:0] b_in = 32'd0;
   logic        operator_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        sign_out;
   logic [7:0]  exp_out;
   logic [25:0] mantis_out;
   logic        operator_out;
   logic        loss;

   int total = 0;
   int bad = 0;

   logic        o_sign, o_eop, o_loss;
   logic [7:0]  o_exp;
   logic [25:0] o_mant;

   fp_align_add #(.MAX_SHIFT(MAX)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .operator_in(operator_in),
      .out_valid(out_valid), .out_ready(out_ready), .sign_out(sign_out),
      .exp_out(exp_out), .mantis_out(mantis_out), .operator_out(operator_out),
      .loss(loss)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Result computed from values: magnitudes as integers, shift as division, sticky as remainder.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic op,
                                 output logic s, output logic [7:0] e, output logic [25:0] m,
                                 output logic eo, output logic ls, output int lat);
      longint ma, mb, ka, kb, ml, ms, sh, r;
      int ea, eb, el, es, n;
      logic sl;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      ma = (ea == 0) ? 0 : (longint'(1) << 24) + longint'(a[22:0]) * 2;
      mb = (eb == 0) ? 0 : (longint'(1) << 24) + longint'(b[22:0]) * 2;
      ka = (ea == 0) ? 0 : longint'(a[30:0]);
      kb = (eb == 0) ? 0 : longint'(b[30:0]);
      eo = a[31] ^ b[31] ^ op;
      if (ka >= kb) begin
         ml = ma; ms = mb; el = ea; es = eb; sl = a[31];
      end else begin
         ml = mb; ms = ma; el = eb; es = ea; sl = b[31] ^ op;
      end
      n = (el - es < MAX) ? el - es : MAX;
      sh = ms / (longint'(1) << n);
      ls = (ms % (longint'(1) << n)) != 0;
      r = eo ? ml - sh : ml + sh;
      if (eo && r == 0) begin
         s = 1'b0; e = 8'd0; m = 26'd0; ls = 1'b0;
      end else begin
         s = sl; e = 8'(el); m = 26'(r);
      end
      lat = n + 1;
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op, input int hold);
      logic es, eeo, els;
      logic [7:0] ee;
      logic [25:0] em;
      int elat, w, cyc;
      model(a, b, op, es, ee, em, eeo, els, elat);
      w = 0;
      while (!in_ready && w < 100) begin
         @(posedge clk); #1; w++;
      end
      chk("in_ready_before_issue", 32'(in_ready), 32'd1);
      a_in = a; b_in = b; operator_in = op; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(posedge clk); #1; cyc++;
      end
      chk("latency", 32'(cyc), 32'(elat));
      chk("sign_out", 32'(sign_out), 32'(es));
      chk("exp_out", 32'(exp_out), 32'(ee));
      chk("mantis_out", 32'(mantis_out), 32'(em));
      chk("operator_out", 32'(operator_out), 32'(eeo));
      chk("loss", 32'(loss), 32'(els));
      o_sign = sign_out; o_exp = exp_out; o_mant = mantis_out; o_eop = operator_out; o_loss = loss;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_mantis", 32'(mantis_out), 32'(em));
         chk("hold_exp", 32'(exp_out), 32'(ee));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_out_valid", 32'(out_valid), 32'd0);
      chk("release_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] ra, rb;
      int ea, eb, mode;
      int seen;

      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mantis", 32'(mantis_out), 32'd0);
      chk("rst_exp", 32'(exp_out), 32'd0);
      chk("rst_sign", 32'(sign_out), 32'd0);
      chk("rst_operator_out", 32'(operator_out), 32'd0);
      chk("rst_loss", 32'(loss), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      run_op(32'h3F800000, 32'h3F800000, 1'b0, 0);
      chk("dir1_exp", 32'(o_exp), 32'h7F);
      chk("dir1_mant", 32'(o_mant), 32'h2000000);
      chk("dir1_sign", 32'(o_sign), 32'd0);

      run_op(32'h3F800000, 32'h3F000000, 1'b0, 0);
      chk("dir2_mant", 32'(o_mant), 32'h1800000);
      chk("dir2_loss", 32'(o_loss), 32'd0);

      run_op(32'h3F800000, 32'h40000000, 1'b1, 5);
      chk("dir3_sign", 32'(o_sign), 32'd1);
      chk("dir3_exp", 32'(o_exp), 32'h80);
      chk("dir3_mant", 32'(o_mant), 32'h0800000);
      chk("dir3_eop", 32'(o_eop), 32'd1);

      run_op(32'h3F800000, 32'h30800000, 1'b0, 0);
      chk("dir4_exp", 32'(o_exp), 32'h7F);
      chk("dir4_mant", 32'(o_mant), 32'h1000000);
      chk("dir4_loss", 32'(o_loss), 32'd1);

      run_op(32'h3F800000, 32'h3F800000, 1'b1, 0);
      chk("dir5_zero_mant", 32'(o_mant), 32'd0);
      chk("dir5_zero_exp", 32'(o_exp), 32'd0);
      chk("dir5_zero_sign", 32'(o_sign), 32'd0);

      // Reset in the tenth ALIGN cycle of a capped shift must discard the operation.
      a_in = 32'h3F800000; b_in = 32'h30800000; operator_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_loss", 32'(loss), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      seen = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("midrst_no_stale_result", 32'(seen), 32'd0);
      run_op(32'h3F800000, 32'h3F000000, 1'b0, 0);

      for (int k = 0; k < 60; k++) begin
         mode = int'($urandom_range(0, 3));
         ea = int'($urandom_range(0, 254));
         if (mode == 0) eb = int'($urandom_range(0, 254));
         else eb = ea + int'($urandom_range(0, 6)) - 3;
         if (eb < 0) eb = 0;
         if (eb > 254) eb = 254;
         ra = {1'($urandom), 8'(ea), 23'($urandom)};
         rb = {1'($urandom), 8'(eb), 23'($urandom)};
         if (mode == 3) rb = {1'($urandom), ra[30:0]};
         run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
